icache_responder: RTL and testbench

- Direct-mapped, one-word-per-block instruction cache: the cache-side responder of the datapath/cache interface.
- Serves the datapath's instruction fetch (imemREN, imemaddr) with ihit and imemload.
- On a miss, issues single-word reads (iREN, iaddr) to the memory controller, fills the frame, then hits.
- Sits between the pipelined datapath and the memory controller; keeps saturating hit/miss counters for performance reporting.

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/icache_responder_if.sv | 21 ++
 rtl/icache_responder.sv | 95 +++++++++
 tb/tb_icache_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word plus the instruction-cache address decode,
// frame layout and responder state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_TAG_W = 26;
    localparam int ICACHE_IDX_W = 4;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_responder_if.sv
// Fetch-side (datapath <-> cache) and memory-side (cache <-> controller)
// signals; the responder takes the cache and icache views.
interface icache_responder_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;

    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    modport cache  (input imemREN, imemaddr, output ihit, imemload);
    modport dp     (output imemREN, imemaddr, input ihit, imemload);
    modport icache (output iREN, iaddr, input iwait, iload);
    modport mem    (input iREN, iaddr, output iwait, iload);

endinterface

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-frame instruction cache with same-cycle hits,
// single-word miss fills and saturating hit/miss counters.
module icache_responder
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int CNT_W = 16
) (
    input  logic                     CLK,
    input  logic                     nRST,
    icache_responder_if.cache        dcif,
    icache_responder_if.icache       ccif,
    output logic [CNT_W-1:0]         hit_count,
    output logic [CNT_W-1:0]         miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    icache_state_t     state_q;
    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q [SETS];
    word_t             data_q [SETS];
    word_t             miss_addr_q;
    logic [CNT_W-1:0]  hit_cnt_q;
    logic [CNT_W-1:0]  miss_cnt_q;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic              hit;
    logic              miss;
    logic              fill;

    assign req_tag  = dcif.imemaddr[31:IDX_W+2];
    assign req_idx  = dcif.imemaddr[IDX_W+1:2];
    assign fill_tag = miss_addr_q[31:IDX_W+2];
    assign fill_idx = miss_addr_q[IDX_W+1:2];

    assign hit  = (state_q == IDLE) && dcif.imemREN && valid_q[req_idx]
                  && (tag_q[req_idx] == req_tag);
    assign miss = (state_q == IDLE) && dcif.imemREN && !hit;
    assign fill = (state_q == FETCH) && !ccif.iwait;

    // Hit path is combinational so a resident instruction costs no stall.
    assign dcif.ihit     = hit;
    assign dcif.imemload = hit ? data_q[req_idx] : '0;
    assign ccif.iREN     = (state_q == FETCH);
    assign ccif.iaddr    = (state_q == FETCH) ? miss_addr_q : '0;

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            miss_addr_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            if (hit && !(&hit_cnt_q))
                hit_cnt_q <= hit_cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    if (miss) begin
                        state_q     <= FETCH;
                        miss_addr_q <= {dcif.imemaddr[31:2], 2'b00};
                        if (!(&miss_cnt_q))
                            miss_cnt_q <= miss_cnt_q + 1'b1;
                    end
                end
                FETCH: begin
                    // The fill targets the latched address, whatever the
                    // datapath is presenting now.
                    if (fill) begin
                        valid_q[fill_idx] <= 1'b1;
                        state_q           <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; the valid bits qualify them.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= ccif.iload;
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Directed scenarios followed by random fetch traffic, compared cycle by
// cycle against a line-address lookup model of the cache.
module tb_icache_responder;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    logic [15:0] hc, mc;
    logic [3:0]  hc4, mc4;

    icache_responder_if dif();
    icache_responder_if sif();

    assign sif.imemREN  = dif.imemREN;
    assign sif.imemaddr = dif.imemaddr;
    assign sif.iwait    = dif.iwait;
    assign sif.iload    = dif.iload;

    icache_responder #(.SETS(16), .CNT_W(16)) dut (
        .CLK(CLK), .nRST(nRST), .dcif(dif), .ccif(dif),
        .hit_count(hc), .miss_count(mc));

    icache_responder #(.SETS(16), .CNT_W(4)) dut_sat (
        .CLK(CLK), .nRST(nRST), .dcif(sif), .ccif(sif),
        .hit_count(hc4), .miss_count(mc4));

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Model: each of 16 slots remembers which word address it holds.
    bit          m_valid [16];
    logic [29:0] m_line  [16];
    word_t       m_data  [16];
    bit          m_pend;
    word_t       m_paddr;
    int          m_hits, m_miss;
    bit          m_hit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
        m_pend = 0; m_paddr = '0; m_hits = 0; m_miss = 0;
    endtask

    // Drive one cycle's inputs and compare the outputs mid-cycle.
    task automatic cyc_a(input logic ren, input word_t addr, input logic wt, input word_t ld);
        int idx;
        dif.imemREN = ren; dif.imemaddr = addr; dif.iwait = wt; dif.iload = ld;
        #3;
        idx = int'(addr[5:2]);
        m_hit = !m_pend && ren && m_valid[idx] && (m_line[idx] == addr[31:2]);
        chk("ihit",     {31'b0, dif.ihit}, {31'b0, m_hit});
        chk("imemload", dif.imemload, m_hit ? m_data[idx] : 32'h0);
        chk("iREN",     {31'b0, dif.iREN}, {31'b0, m_pend});
        chk("iaddr",    dif.iaddr, m_pend ? m_paddr : 32'h0);
        chk("hit_count",  {16'b0, hc},  32'(sat(m_hits, 65535)));
        chk("miss_count", {16'b0, mc},  32'(sat(m_miss, 65535)));
        chk("hit_count4", {28'b0, hc4}, 32'(sat(m_hits, 15)));
        chk("miss_count4",{28'b0, mc4}, 32'(sat(m_miss, 15)));
    endtask

    task automatic cyc_b();
        int idx;
        @(posedge CLK);
        if (m_pend) begin
            if (!dif.iwait) begin
                idx = int'(m_paddr[5:2]);
                m_valid[idx] = 1; m_line[idx] = m_paddr[31:2];
                m_data[idx] = dif.iload; m_pend = 0;
            end
        end else if (m_hit) begin
            m_hits++;
        end else if (dif.imemREN) begin
            m_pend = 1; m_paddr = {dif.imemaddr[31:2], 2'b00}; m_miss++;
        end
        #1;
    endtask

    task automatic cyc(input logic ren, input word_t addr, input logic wt, input word_t ld);
        cyc_a(ren, addr, wt, ld);
        cyc_b();
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        dif.imemREN = 1'b0; dif.imemaddr = '0; dif.iwait = 1'b1; dif.iload = '0;
        model_reset();
        #1;
        chk("rst_ihit", {31'b0, dif.ihit}, 32'h0);
        chk("rst_iREN", {31'b0, dif.iREN}, 32'h0);
        chk("rst_iaddr", dif.iaddr, 32'h0);
        chk("rst_imemload", dif.imemload, 32'h0);
        chk("rst_counts", {hc, mc}, 32'h0);
        @(posedge CLK); #1;
        nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b0;
        dif.imemREN = 1'b0; dif.imemaddr = '0; dif.iwait = 1'b1; dif.iload = '0;
        model_reset();
        #1;
        do_reset();

        // Cold miss with three busy cycles.
        cyc(1, 32'h0, 1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc_a(1, 32'h0, 1, 32'hDEAD0000 + i);
            chk("cold_iREN", {31'b0, dif.iREN}, 32'h1);
            cyc_b();
        end
        cyc(1, 32'h0, 0, 32'h3C010004);
        cyc_a(1, 32'h0, 1, 32'h0);
        chk("cold_hit_load", dif.imemload, 32'h3C010004);
        chk("cold_miss_count", {16'b0, mc}, 32'h1);
        cyc_b();

        // Hit stream, then continue into counter saturation.
        do_reset();
        cyc(1, 32'h0, 0, 32'h11111111);
        cyc(1, 32'h0, 0, 32'h11111111);
        cyc(1, 32'h4, 0, 32'h22222222);
        cyc(1, 32'h4, 0, 32'h22222222);
        for (int i = 0; i < 10; i++) cyc(1, (i % 2) ? 32'h4 : 32'h0, 1, 32'h0);
        chk("stream_hits", {16'b0, hc}, 32'd10);
        for (int i = 0; i < 10; i++) cyc(1, (i % 2) ? 32'h4 : 32'h0, 1, 32'h0);
        chk("sat_hits4", {28'b0, hc4}, 32'd15);
        chk("sat_hits16", {16'b0, hc}, 32'd20);

        // Conflict eviction in frame 0.
        do_reset();
        cyc(1, 32'h0, 0, 32'hA0);  cyc(1, 32'h0, 0, 32'hA0);
        cyc(1, 32'h40, 0, 32'hB0); cyc(1, 32'h40, 0, 32'hB0);
        cyc(1, 32'h40, 1, 32'h0);
        cyc(1, 32'h0, 0, 32'hC0);  cyc(1, 32'h0, 0, 32'hC0);
        cyc_a(1, 32'h0, 1, 32'h0);
        chk("conflict_misses", {16'b0, mc}, 32'd3);
        chk("conflict_load", dif.imemload, 32'hC0);
        cyc_b();

        // Address changes while a fill is outstanding.
        do_reset();
        cyc(1, 32'h8, 1, 32'h0);
        cyc_a(1, 32'hC, 1, 32'h0);
        chk("midfetch_iaddr", dif.iaddr, 32'h8);
        cyc_b();
        cyc(1, 32'hC, 0, 32'hD8);
        cyc(1, 32'hC, 1, 32'h0);
        cyc_a(1, 32'hC, 1, 32'h0);
        chk("second_iaddr", dif.iaddr, 32'hC);
        cyc_b();
        cyc(1, 32'hC, 0, 32'hDC);
        cyc_a(1, 32'h8, 1, 32'h0);
        chk("frame2_load", dif.imemload, 32'hD8);
        cyc_b();

        // Reset during a fetch drops iREN at once and invalidates everything.
        do_reset();
        cyc(1, 32'h0, 0, 32'h55);  cyc(1, 32'h0, 0, 32'h55);
        cyc(1, 32'h4, 1, 32'h0);
        cyc_a(1, 32'h4, 1, 32'h0);
        chk("pre_rst_iREN", {31'b0, dif.iREN}, 32'h1);
        nRST = 1'b0;
        #1;
        chk("async_rst_iREN", {31'b0, dif.iREN}, 32'h0);
        model_reset();
        @(posedge CLK); #1;
        nRST = 1'b1;
        cyc_a(1, 32'h0, 1, 32'h0);
        chk("post_rst_miss", {31'b0, dif.ihit}, 32'h0);
        cyc_b();

        // Random traffic over a few tags so frames collide.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            word_t a;
            a = {28'(($urandom_range(0, 2)) << 2), 4'($urandom_range(0, 15))};
            a = (a << 2) | 32'($urandom_range(0, 3));
            cyc(($urandom_range(0, 9) < 8), a, ($urandom_range(0, 1) == 1), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
